spi_rdid_ctrl: RTL and testbench
================================

Name: spi_rdid_ctrl

Overview:
- SPI master transaction engine that sits directly downstream of the button one-shot: a single-cycle `start` pulse launches one Read-ID transaction to the attached SPI device.
- It drives the chip select (CS), serial clock (SCLK) and MOSI lines, shifts out an 8-bit command, then shifts in `NUM_BYTES` ID bytes.
- It presents the captured ID word, with a one-cycle `done` strobe, to the display/debug logic.

Parameters:
- CLK_DIV, 2, number of clk cycles per SCLK half-period; legal range ≥1.
- NUM_BYTES, 3, number of ID bytes read after the command; legal range 1..4.
- CMD, 8'h9F, command byte shifted out MSB first.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle request pulse from the one-shot; sampled only in IDLE.
- miso, input, 1, serial data from the device.
- cs_n, output, 1, active-low chip select.
- sclk, output, 1, SPI clock, mode 0 (idle low).
- mosi, output, 1, serial data to the device.
- busy, output, 1, high from the cycle after start is accepted until done deasserts.
- done, output, 1, one-cycle completion strobe.
- rdid_data, output, 8*NUM_BYTES, last captured ID; the first received byte is in the MSBs.

Behaviour:
- Clock and reset: rst is asynchronous, active-high; clock is clk.
- Reset values: cs_n=1, sclk=0, mosi=0, busy=0, done=0, rdid_data=0, state=IDLE, all counters 0.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE:
  - cs_n=1, sclk=0, mosi=0.
  - start=1 moves to SETUP on the next edge.
  - start in any other state is ignored; no queuing.
- SETUP:
  - lasts CLK_DIV cycles.
  - cs_n=0, busy=1, sclk=0, mosi=CMD[7].
- SHIFT:
  - Shifts 8+8*NUM_BYTES bits.
  - Each bit is a low half (CLK_DIV cycles, sclk=0) followed by a high half (CLK_DIV cycles, sclk=1).
  - miso is sampled into the internal shift register on the clk edge where sclk goes 0->1; it is ignored during the 8 command bits.
  - mosi changes only on the 1->0 transitions of sclk.
  - Bit order:
    - Command bits are CMD[7] down to CMD[0], MSB first.
    - During read bits, mosi=0.
  - After the high half of the last bit: sclk=0, go to HOLD.
- HOLD:
  - lasts CLK_DIV cycles.
  - cs_n=0, sclk=0, mosi=0.
- DONE:
  - lasts exactly 1 cycle.
  - cs_n=1, done=1, busy=1.
  - rdid_data is loaded from the shift register on entry to this state.
  - Next state is IDLE with busy=0.
- Latency: if start is sampled high at edge T, done is high during the cycle beginning at edge T+1+CLK_DIV*(2+16*(1+NUM_BYTES)).
  - With defaults this is T+133.
- Widths and counters:
  - The bit counter is sized for 8+8*NUM_BYTES.
  - The divider counter counts 0..CLK_DIV-1 and wraps.
  - No arithmetic overflow is permitted at the maximum parameter values.
- rdid_data holds its value between transactions; it is never partially updated.
- Reset mid-transaction:
  - All outputs return to reset values immediately (asynchronously); cs_n rises without waiting for an SCLK boundary.
  - rdid_data is cleared to 0.
- All outputs are registered; no combinational path from miso or start to any output.

Test Plan:
- Defaults; device model returns 0x20, 0xBA, 0x18 after the command; pulse start → mosi shows 1001_1111 on the first 8 rising sclk edges, exactly 32 rising sclk edges total, done at T+133, rdid_data=24'h20BA18, cs_n low for the whole transfer.
- Mid-transfer start:
  - Pulse start again at T+40 → ignored: still 32 SCLK rising edges, a single done.
  - A new start in the cycle after done → a second transaction with the new model data 0xEF, 0x40, 0x16 → rdid_data=24'hEF4016.
- CLK_DIV=1, NUM_BYTES=1, model byte 0xA5 → every sclk half lasts 1 cycle, done at T+35, rdid_data=8'hA5.
- Assert rst at T+60 for 2 cycles → cs_n=1, sclk=0, busy=0, rdid_data=0 immediately; a subsequent start yields a complete, correct transaction.
- miso toggling randomly during the command phase, then fixed data 0xFF,0x00,0x55 → rdid_data=24'hFF0055 (command-phase miso is ignored).
- Timing check: mosi stable for ≥CLK_DIV cycles around every rising sclk edge; sclk=0 whenever cs_n=1.

Source files
------------

// File: rtl/spi_rdid_ctrl.sv
// spi_rdid_ctrl: SPI mode-0 master that issues one Read-ID command per start
// pulse and returns the NUM_BYTES-byte ID word with a one-cycle done strobe.
//
// Handshake: start is a one-cycle request that is accepted only while the
// engine is idle (requests at any other time are dropped, never queued).
// busy rises the cycle after acceptance and stays high through the done
// cycle. done pulses for exactly one cycle, and rdid_data is valid from that
// cycle until the next completed transaction or reset.
//
// Every output is a register loaded from a decode of the current state. This
// means pins trail the state register by one cycle, which gives the
// start-to-done latency of 1 + CLK_DIV*(2 + 16*(1+NUM_BYTES)) cycles.
module spi_rdid_ctrl #(
  parameter int          CLK_DIV   = 2,
  parameter int          NUM_BYTES = 3,
  parameter logic [7:0]  CMD       = 8'h9F
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     miso,
  output logic                     cs_n,
  output logic                     sclk,
  output logic                     mosi,
  output logic                     busy,
  output logic                     done,
  output logic [8*NUM_BYTES-1:0]   rdid_data,
  output logic [2:0]               dbg_state_o
);

  localparam int DW    = 8 * NUM_BYTES;
  localparam int NBITS = 8 + DW;
  localparam int BIT_W = $clog2(NBITS);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [BIT_W-1:0] CMD_BITS = BIT_W'(8);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              phase_q, phase_d;   // 0 = sclk low half, 1 = high half
  logic [DW-1:0]     shreg_q, shreg_d;
  logic [DW-1:0]     rdid_q, rdid_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sample_en;

  // State register and divider/bit/phase counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic: each phase lasts CLK_DIV cycles of the divider.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          div_d   = '0;
        end
      end
      S_SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = S_HOLD;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state; registered below so pins are glitch-free.
  always_comb begin
    cs_n_d = 1'b1;
    sclk_d = 1'b0;
    mosi_d = 1'b0;
    busy_d = (state_q != S_IDLE);
    done_d = 1'b0;
    case (state_q)
      S_SETUP: begin
        cs_n_d = 1'b0;
        mosi_d = CMD[7];
      end
      S_SHIFT: begin
        cs_n_d = 1'b0;
        sclk_d = phase_q;
        // bit_q only advances at the end of a high half, so mosi moves with sclk 1->0.
        mosi_d = (bit_q < CMD_BITS) ? CMD[3'd7 - bit_q[2:0]] : 1'b0;
      end
      S_HOLD: begin
        cs_n_d = 1'b0;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture miso on the edge where registered sclk goes high, skipping command bits.
  always_comb begin
    sample_en = (state_q == S_SHIFT) && phase_q && (div_q == '0) && (bit_q >= CMD_BITS);
    shreg_d   = sample_en ? {shreg_q[DW-2:0], miso} : shreg_q;
    rdid_d    = (state_q == S_DONE) ? shreg_q : rdid_q;
  end

  // Shift register and the held ID word (updated whole, never partially).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      rdid_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      rdid_q  <= rdid_d;
    end
  end

  // Registered pins; reset forces the idle bus levels immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n_q <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cs_n_q <= cs_n_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign cs_n        = cs_n_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rdid_data   = rdid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_rdid_ctrl.sv
// Bench for spi_rdid_ctrl: a default instance (CLK_DIV=2, NUM_BYTES=3) and a
// minimal one (CLK_DIV=1, NUM_BYTES=1) share clk/rst. A behavioural SPI device
// per instance serves ID bytes and watches bus timing.
module tb_spi_rdid_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic        start_w [2];
  logic        miso_w  [2];
  logic        cs_n_w  [2];
  logic        sclk_w  [2];
  logic        mosi_w  [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic [23:0] rdid0;
  logic [7:0]  rdid1;
  logic [2:0]  dbg0, dbg1;

  spi_rdid_ctrl #(.CLK_DIV(2), .NUM_BYTES(3), .CMD(8'h9F)) dut0 (
    .clk(clk), .rst(rst), .start(start_w[0]), .miso(miso_w[0]),
    .cs_n(cs_n_w[0]), .sclk(sclk_w[0]), .mosi(mosi_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .rdid_data(rdid0), .dbg_state_o(dbg0)
  );

  spi_rdid_ctrl #(.CLK_DIV(1), .NUM_BYTES(1), .CMD(8'h9F)) dut1 (
    .clk(clk), .rst(rst), .start(start_w[1]), .miso(miso_w[1]),
    .cs_n(cs_n_w[1]), .sclk(sclk_w[1]), .mosi(mosi_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .rdid_data(rdid1), .dbg_state_o(dbg1)
  );

  function automatic int nby(input int g);
    return (g == 0) ? 3 : 1;
  endfunction

  function automatic int cdv(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  // ---------------- device model / bus monitor ----------------
  logic [31:0] dev_data   [2] = '{32'h0, 32'h0};
  int          rise_cnt   [2] = '{0, 0};
  int          sess_rises [2] = '{0, 0};
  int          stab       [2] = '{0, 0};
  int          viol       [2] = '{0, 0};
  int          done_cnt   [2] = '{0, 0};
  logic [7:0]  cmd_cap    [2] = '{8'h0, 8'h0};
  logic        sclk_p     [2] = '{1'b0, 1'b0};
  logic        cs_p       [2] = '{1'b1, 1'b1};
  logic        mosi_p     [2] = '{1'b0, 1'b0};

  initial begin
    miso_w[0] = 1'b0;
    miso_w[1] = 1'b0;
  end

  // Device: mode 0, next bit presented after each sclk fall; random noise on
  // miso outside the ID bytes. Monitor: cmd bits, rise count, timing rules.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (cs_p[g] && !cs_n_w[g]) begin
        rise_cnt[g] = 0;
        cmd_cap[g]  = 8'h0;
      end
      if (!cs_p[g] && cs_n_w[g]) sess_rises[g] = rise_cnt[g];
      if (cs_n_w[g] && sclk_w[g]) viol[g]++;
      if (mosi_w[g] !== mosi_p[g]) begin
        if (sclk_w[g]) viol[g]++;
        stab[g] = 1;
      end else begin
        stab[g]++;
      end
      if (sclk_w[g] && !sclk_p[g]) begin
        if (stab[g] < cdv(g)) viol[g]++;
        if (rise_cnt[g] < 8) cmd_cap[g] = {cmd_cap[g][6:0], mosi_w[g]};
        else if (mosi_w[g] !== 1'b0) viol[g]++;
        rise_cnt[g]++;
      end
      if (!sclk_w[g] && sclk_p[g] && rise_cnt[g] >= 8 && rise_cnt[g] < 8 + 8 * nby(g))
        miso_w[g] = dev_data[g][8 * nby(g) - 1 - (rise_cnt[g] - 8)];
      else if (cs_n_w[g] || rise_cnt[g] < 8)
        miso_w[g] = 1'($urandom_range(0, 1));
      if (done_w[g]) done_cnt[g]++;
      sclk_p[g] = sclk_w[g];
      cs_p[g]   = cs_n_w[g];
      mosi_p[g] = mosi_w[g];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_pulse(input int g, output int t);
    start_w[g] = 1'b1;
    t = cyc + 1;
    step();
    start_w[g] = 1'b0;
    chk("busy_before_accept", busy_w[g], 0);
  endtask

  task automatic run_txn(input int g, input logic [31:0] data, input int mid_at);
    int t, done_at, lat, dcnt0;
    logic [31:0] got;
    dev_data[g] = data;
    lat = 1 + cdv(g) * (2 + 16 * (1 + nby(g)));
    exp_q.push_back((g == 0) ? {8'h0, data[23:0]} : {24'h0, data[7:0]});
    dcnt0 = done_cnt[g];
    start_pulse(g, t);
    done_at = -1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (i == 0) chk("busy_rise", busy_w[g], 1);
      start_w[g] = (mid_at > 0 && cyc == t + mid_at - 1);
      if (done_w[g]) begin
        done_at = cyc;
        break;
      end
    end
    start_w[g] = 1'b0;
    chk("done_seen", done_at >= 0, 1);
    chk("latency", done_at - t, lat);
    got = (g == 0) ? {8'h0, rdid0} : {24'h0, rdid1};
    chk("rdid", got, exp_q.pop_front());
    chk("busy_at_done", busy_w[g], 1);
    chk("cs_n_at_done", cs_n_w[g], 1);
    chk("cmd_bits", cmd_cap[g], 8'h9F);
    chk("sclk_rises", sess_rises[g], 8 + 8 * nby(g));
    step();
    chk("done_one_cycle", done_w[g], 0);
    chk("busy_fall", busy_w[g], 0);
    chk("done_count", done_cnt[g] - dcnt0, 1);
    chk("bus_timing", viol[g], 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    start_w[0] = 1'b0;
    start_w[1] = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    for (int g = 0; g < 2; g++) begin
      chk("rst_cs_n", cs_n_w[g], 1);
      chk("rst_sclk", sclk_w[g], 0);
      chk("rst_mosi", mosi_w[g], 0);
      chk("rst_busy", busy_w[g], 0);
      chk("rst_done", done_w[g], 0);
    end
    chk("rst_rdid0", {8'h0, rdid0}, 0);
    chk("rst_rdid1", {24'h0, rdid1}, 0);
    rst = 1'b0;
    repeat (2) step();

    // Default transfer with an ignored start mid-transfer, then back-to-back.
    run_txn(0, 32'h0020BA18, 40);
    run_txn(0, 32'h00EF4016, 0);

    // Minimal parameters.
    run_txn(1, 32'h000000A5, 0);

    // Reset mid-transaction.
    dev_data[0] = $urandom;
    start_pulse(0, t);
    for (int i = 0; i < 200 && cyc < t + 60; i++) step();
    rst = 1'b1;
    #1;
    chk("midrst_cs_n", cs_n_w[0], 1);
    chk("midrst_sclk", sclk_w[0], 0);
    chk("midrst_mosi", mosi_w[0], 0);
    chk("midrst_busy", busy_w[0], 0);
    chk("midrst_done", done_w[0], 0);
    chk("midrst_rdid0", {8'h0, rdid0}, 0);
    chk("midrst_rdid1", {24'h0, rdid1}, 0);
    step();
    step();
    rst = 1'b0;
    step();
    run_txn(0, $urandom, 0);

    // Random command-phase miso followed by fixed ID bytes.
    run_txn(0, 32'h00FF0055, 0);

    // Random ID words on both instances.
    for (int k = 0; k < 6; k++) run_txn(k % 2, $urandom, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
